// File: rtl/obi_periph_addr_demux.sv
// obi_periph_addr_demux: 1-to-N OBI peripheral demux with in-order response tracking and an error responder.
// Define OBI_DEMUX_ERR_COUNT_EN to enable the saturating unmapped-access counter; ADDR_RULES row = {idx, start_addr, end_addr}.
module obi_periph_addr_demux #(
    parameter int unsigned NUM_SLAVES = 13,
    parameter logic [NUM_SLAVES-1:0][2:0][31:0] ADDR_RULES = {
        {32'd12, 32'h200B_0000, 32'h200C_0000},
        {32'd11, 32'h200A_0000, 32'h200B_0000},
        {32'd10, 32'h2009_0000, 32'h200A_0000},
        {32'd9,  32'h2008_0000, 32'h2009_0000},
        {32'd8,  32'h2007_0000, 32'h2008_0000},
        {32'd7,  32'h2006_0000, 32'h2007_0000},
        {32'd6,  32'h2005_0000, 32'h2006_0000},
        {32'd5,  32'h2004_0000, 32'h2005_0000},
        {32'd4,  32'h2003_0000, 32'h2004_0000},
        {32'd3,  32'h2002_8000, 32'h2003_0000},
        {32'd2,  32'h2002_0000, 32'h2002_8000},
        {32'd1,  32'h2001_0000, 32'h2002_0000},
        {32'd0,  32'h2000_0000, 32'h2001_0000}
    },
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] ERR_RDATA = 32'hBADACCE5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        m_req_i,
    output logic                        m_gnt_o,
    input  logic [31:0]                 m_addr_i,
    input  logic                        m_we_i,
    input  logic [3:0]                  m_be_i,
    input  logic [31:0]                 m_wdata_i,
    output logic                        m_rvalid_o,
    output logic [31:0]                 m_rdata_o,
    output logic [NUM_SLAVES-1:0]       s_req_o,
    input  logic [NUM_SLAVES-1:0]       s_gnt_i,
    output logic [31:0]                 s_addr_o,
    output logic                        s_we_o,
    output logic [3:0]                  s_be_o,
    output logic [31:0]                 s_wdata_o,
    input  logic [NUM_SLAVES-1:0]       s_rvalid_i,
    input  logic [NUM_SLAVES-1:0][31:0] s_rdata_i,
    output logic                        err_o,
    output logic [15:0]                 err_count_o
);
    localparam int unsigned TW = $clog2(NUM_SLAVES + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned EW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [TW-1:0] ERR = TW'(NUM_SLAVES);

    logic [TW-1:0] target, head, last_target_q, last_target_d;
    logic [MAX_OUTSTANDING-1:0][TW-1:0] fifo_q, fifo_d;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] err_pend_q, err_pend_d;
    logic [NUM_SLAVES:0] gnt_ext, rvalid_ext;
    logic allow, push, pop, empty, full;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Reverse scan so the lowest matching rule is assigned last and wins.
    always_comb begin
        target = ERR;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if (m_addr_i >= ADDR_RULES[i][1] && m_addr_i < ADDR_RULES[i][0])
                target = TW'(ADDR_RULES[i][2]);
    end

    assign empty      = cnt_q == '0;
    assign full       = cnt_q == CW'(MAX_OUTSTANDING);
    assign head       = fifo_q[rptr_q];
    assign allow      = !full && (empty || target == last_target_q);
    assign gnt_ext    = {1'b1, s_gnt_i};
    assign rvalid_ext = {err_pend_q != '0, s_rvalid_i};

    assign s_req_o    = (m_req_i && allow && target != ERR) ? NUM_SLAVES'(1) << target : '0;
    assign m_gnt_o    = m_req_i && allow && gnt_ext[target];
    assign s_addr_o   = m_addr_i;
    assign s_we_o     = m_we_i;
    assign s_be_o     = m_be_i;
    assign s_wdata_o  = m_wdata_i;

    assign m_rvalid_o = !empty && rvalid_ext[head];
    assign m_rdata_o  = !m_rvalid_o ? '0 : (head == ERR ? ERR_RDATA : s_rdata_i[head]);
    assign err_o      = m_rvalid_o && head == ERR;
    assign push       = m_req_i && m_gnt_o;
    assign pop        = m_rvalid_o;

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wptr_q] = target;
        wptr_d        = push ? nxt(wptr_q) : wptr_q;
        rptr_d        = pop ? nxt(rptr_q) : rptr_q;
        cnt_d         = cnt_q + CW'(push) - CW'(pop);
        last_target_d = push ? target : last_target_q;
        err_pend_d    = err_pend_q + EW'(push && target == ERR) - EW'(err_o);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fifo_q        <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
            last_target_q <= '0;
            err_pend_q    <= '0;
        end else begin
            fifo_q        <= fifo_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            cnt_q         <= cnt_d;
            last_target_q <= last_target_d;
            err_pend_q    <= err_pend_d;
        end
    end

`ifdef OBI_DEMUX_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb err_count_d = (err_o && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) err_count_q <= '0;
        else err_count_q <= err_count_d;
    end

    assign err_count_o = err_count_q;
`else
    assign err_count_o = 16'h0;
`endif
endmodule

// File: tb/tb_obi_periph_addr_demux.sv
// tb_obi_periph_addr_demux: directed plus randomized check of obi_periph_addr_demux against a queue-based model.
module tb_obi_periph_addr_demux;
    localparam int NS = 13;
    localparam int MAXO = 2;
    localparam logic [31:0] ERRD = 32'hBADACCE5;
`ifdef OBI_DEMUX_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_ni = 1'b0;
    logic m_req_i, m_gnt_o, m_we_i, m_rvalid_o, s_we_o, err_o;
    logic [31:0] m_addr_i, m_wdata_i, m_rdata_o, s_addr_o, s_wdata_o;
    logic [3:0] m_be_i, s_be_o;
    logic [NS-1:0] s_req_o, s_gnt_i, s_rvalid_i;
    logic [NS-1:0][31:0] s_rdata_i;
    logic [15:0] err_count_o;

    int checks = 0, failures = 0;
    int mq[$];
    longint mgc[$];
    int last_t = 0, exp_cnt = 0;
    longint cyc = 0;
    bit hold = 0;
    int pend_n[NS];

    // Peripheral map as [base, next base): rule i covers rbase[i] .. rbase[i+1]-1 and routes to port i.
    logic [31:0] rbase [NS+1] = '{32'h2000_0000, 32'h2001_0000, 32'h2002_0000, 32'h2002_8000, 32'h2003_0000,
                                  32'h2004_0000, 32'h2005_0000, 32'h2006_0000, 32'h2007_0000, 32'h2008_0000,
                                  32'h2009_0000, 32'h200A_0000, 32'h200B_0000, 32'h200C_0000};
    logic [31:0] unm [5] = '{32'h200F_0000, 32'h200C_0000, 32'h1FFF_FFFC, 32'h0000_0000, 32'hFFFF_FFF0};

    obi_periph_addr_demux dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .err_o(err_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) if (a >= rbase[i] && a < rbase[i+1]) return i;
        return NS;
    endfunction

    // Outstanding targets live in mq (oldest first); an error entry answers once a cycle has passed since its grant.
    task automatic model_step();
        int t, h;
        bit emp, rv, al, g;
        logic [31:0] rd;
        logic [NS-1:0] sr;
        if (!rst_ni) begin
            mq.delete();
            mgc.delete();
            exp_cnt = 0;
            hold = 0;
            cyc++;
            return;
        end
        t = decode(m_addr_i);
        emp = mq.size() == 0;
        h = emp ? NS : mq[0];
        rv = !emp && (h == NS ? (mgc[0] < cyc) : s_rvalid_i[h]);
        rd = !rv ? 32'h0 : (h == NS ? ERRD : s_rdata_i[h]);
        al = mq.size() < MAXO && (emp || t == last_t);
        g = m_req_i && al && (t == NS || s_gnt_i[t]);
        sr = '0;
        if (m_req_i && al && t != NS) sr[t] = 1'b1;
        chk("gnt", m_gnt_o, g);
        chk("s_req", s_req_o, sr);
        chk("rvalid", m_rvalid_o, rv);
        chk("rdata", m_rdata_o, rd);
        chk("err", err_o, rv && h == NS);
        chk("err_count", err_count_o, CNT_EN ? 64'(exp_cnt) : 64'd0);
        chk("bcast", {s_we_o, s_be_o, s_addr_o}, {m_we_i, m_be_i, m_addr_i});
        chk("wdata", s_wdata_o, m_wdata_i);
        if (rv && h == NS && exp_cnt < 65535) exp_cnt++;
        if (rv) begin
            void'(mq.pop_front());
            void'(mgc.pop_front());
        end
        for (int p = 0; p < NS; p++) if (s_rvalid_i[p] && pend_n[p] > 0) pend_n[p]--;
        if (g) begin
            mq.push_back(t);
            mgc.push_back(cyc);
            last_t = t;
            if (t != NS) pend_n[t]++;
        end
        hold = m_req_i && !g;
        cyc++;
    endtask

    always @(negedge clk) model_step();

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input logic r, input logic [31:0] a, input logic [NS-1:0] gnt, input logic [NS-1:0] rv);
        m_req_i = r;
        m_addr_i = a;
        s_gnt_i = gnt;
        s_rvalid_i = rv;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k, r, j, prev_t;
        logic [31:0] span;
        m_req_i = 0; m_addr_i = 0; m_we_i = 0; m_be_i = 4'hF; m_wdata_i = 0;
        s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0;
        prev_t = 0;
        for (int p = 0; p < NS; p++) pend_n[p] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", m_gnt_o, 0);
        chk("rst_rvalid", m_rvalid_o, 0);
        chk("rst_rdata", m_rdata_o, 0);
        chk("rst_sreq", s_req_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cnt", err_count_o, 0);
        rst_ni = 1;

        // single mapped read to port 12
        req(1, 32'h200B_0004, 13'h1000, 0); tick();
        chk("t1_sreq", s_req_o, 13'h1000);
        chk("t1_gnt", m_gnt_o, 1);
        adv(); req(0, 32'h200B_0004, 13'h1000, 13'h1000); s_rdata_i[12] = 32'h1234; tick();
        chk("t1_rvalid", m_rvalid_o, 1);
        chk("t1_rdata", m_rdata_o, 32'h1234);
        adv(); req(0, 0, 0, 0); tick();
        chk("t1_idle", m_rvalid_o, 0);

        // unmapped read answered by the error responder
        adv(); req(1, 32'h200F_0000, 0, 0); tick();
        chk("t2_gnt", m_gnt_o, 1);
        chk("t2_sreq", s_req_o, 0);
        chk("t2_rv0", m_rvalid_o, 0);
        adv(); req(0, 0, 0, 0); tick();
        chk("t2_rvalid", m_rvalid_o, 1);
        chk("t2_rdata", m_rdata_o, 32'hBADACCE5);
        chk("t2_err", err_o, 1);
        adv(); tick();
        chk("t2_err_off", err_o, 0);
        chk("t2_cnt", err_count_o, CNT_EN ? 64'd1 : 64'd0);

        // two outstanding reads to port 2, third stalls on a full FIFO
        adv(); req(1, 32'h2002_0000, 13'h0004, 0); tick();
        chk("t3_g1", m_gnt_o, 1);
        adv(); req(1, 32'h2002_0004, 13'h0004, 0); tick();
        chk("t3_g2", m_gnt_o, 1);
        adv(); req(1, 32'h2002_0008, 13'h0004, 0); tick();
        chk("t3_stall", m_gnt_o, 0);
        chk("t3_stall_sreq", s_req_o, 0);
        adv(); tick();
        chk("t3_stall2", m_gnt_o, 0);
        adv(); s_rvalid_i = 13'h0004; s_rdata_i[2] = 32'hA1; tick();
        chk("t3_rv1", m_rvalid_o, 1);
        chk("t3_nobypass", m_gnt_o, 0);
        adv(); s_rvalid_i = 0; tick();
        chk("t3_g3", m_gnt_o, 1);
        adv(); req(0, 0, 0, 13'h0004); s_rdata_i[2] = 32'hA2; tick();
        chk("t3_rd2", m_rdata_o, 32'hA2);
        adv(); s_rdata_i[2] = 32'hA3; tick();
        chk("t3_rd3", m_rdata_o, 32'hA3);
        adv(); s_rvalid_i = 0; tick();

        // target switch waits for the idx0 response to drain
        adv(); req(1, 32'h2000_0000, 13'h0081, 0); tick();
        chk("t4_g0", m_gnt_o, 1);
        adv(); req(1, 32'h2006_0000, 13'h0081, 0); tick();
        chk("t4_sreq_hold", s_req_o, 0);
        chk("t4_stall", m_gnt_o, 0);
        adv(); tick();
        adv(); s_rvalid_i = 13'h0001; s_rdata_i[0] = 32'hB0; tick();
        chk("t4_rv0", m_rdata_o, 32'hB0);
        chk("t4_stall_pop", m_gnt_o, 0);
        adv(); s_rvalid_i = 0; tick();
        chk("t4_g7", m_gnt_o, 1);
        chk("t4_sreq7", s_req_o, 13'h0080);
        adv(); req(0, 0, 0, 13'h0080); s_rdata_i[7] = 32'hB7; tick();
        chk("t4_rv7", m_rdata_o, 32'hB7);
        adv(); s_rvalid_i = 0; tick();

        // reset with two transactions outstanding, then a late response
        adv(); req(1, 32'h2002_0010, 13'h0004, 0); tick();
        adv(); m_addr_i = 32'h2002_0014; tick();
        adv(); req(0, 0, 0, 0); rst_ni = 0; tick();
        adv(); rst_ni = 1; tick();
        chk("t5_rvalid", m_rvalid_o, 0);
        chk("t5_sreq", s_req_o, 0);
        chk("t5_err", err_o, 0);
        adv(); s_rvalid_i = 13'h0004; s_rdata_i[2] = 32'hDEAD; tick();
        chk("t5_late", m_rvalid_o, 0);
        chk("t5_late_rdata", m_rdata_o, 0);
        adv(); s_rvalid_i = 0;
        for (int p = 0; p < NS; p++) pend_n[p] = 0;
        tick();

        // randomized traffic checked every cycle by the model
        for (int n = 0; n < 4000; n++) begin
            adv();
            if (!hold) begin
                m_req_i = $urandom_range(9) < 7;
                k = $urandom_range(5);
                r = (k <= 2) ? prev_t : $urandom_range(NS - 1);
                if (k == 0 || r == NS) m_addr_i = unm[$urandom_range(4)];
                else begin
                    span = rbase[r+1] - rbase[r];
                    j = $urandom_range(2);
                    m_addr_i = (j == 0) ? rbase[r] : (j == 1) ? rbase[r+1] - 32'd4 :
                               rbase[r] + 32'($urandom_range((span >> 2) - 1)) * 32'd4;
                end
                m_we_i = 1'($urandom);
                m_be_i = 4'($urandom);
                m_wdata_i = $urandom;
                prev_t = decode(m_addr_i);
            end
            for (int p = 0; p < NS; p++) begin
                s_gnt_i[p] = $urandom_range(3) != 0;
                s_rvalid_i[p] = (pend_n[p] > 0) ? 1'($urandom_range(1)) : ($urandom_range(19) == 0);
                s_rdata_i[p] = $urandom;
            end
            tick();
        end

        adv(); m_req_i = 0;
        for (int n = 0; n < 50 && mq.size() > 0; n++) begin
            for (int p = 0; p < NS; p++) s_rvalid_i[p] = pend_n[p] > 0;
            tick();
            adv();
        end
        s_rvalid_i = 0;
        tick();
        chk("drain", mq.size(), 0);
        chk("drain_rvalid", m_rvalid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/obi_periph_addr_demux.md
Name: obi_periph_addr_demux

Overview:
- 1-to-N OBI demultiplexer between the system crossbar's AO_PERIPHERAL (or PERIPHERAL) slave port and the individual peripheral OBI ports.
- Decodes each request address against the core_v_mini_mcu_pkg address-rule array and forwards the request to the matching port.
- Tracks outstanding transactions so responses return in order.
- Unmapped addresses are answered by an internal error responder.

Parameters:
- NUM_SLAVES, 13, number of downstream peripheral ports (AO_PERIPHERALS).
- ADDR_RULES, core_v_mini_mcu_pkg::AO_PERIPHERALS_ADDR_RULES, addr_map_rule_t[NUM_SLAVES-1:0] decode table.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (≥1).
- ERR_RDATA, 32'hBADACCE5, read data returned for unmapped accesses.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- m_req_i  in  1  upstream request
- m_gnt_o  out  1  upstream grant
- m_addr_i  in  32  request address
- m_we_i  in  1  write enable
- m_be_i  in  4  byte enables
- m_wdata_i  in  32  write data
- m_rvalid_o  out  1  response valid
- m_rdata_o  out  32  response data
- s_req_o  out  NUM_SLAVES  per-port request
- s_gnt_i  in  NUM_SLAVES  per-port grant
- s_addr_o / s_we_o / s_be_o / s_wdata_o  out  32/1/4/32  broadcast request fields
- s_rvalid_i  in  NUM_SLAVES  per-port response valid
- s_rdata_i  in  NUM_SLAVES×32  per-port read data
- err_o  out  1  one-cycle pulse with the error response
- err_count_o  out  16  unmapped-access counter (see Optional Feature)

Behaviour:
- Interface: one clock, clk_i; reset is synchronous and active-low, rst_ni.
- Decode (combinational):
  - Rule i matches when start_addr ≤ m_addr_i < end_addr.
  - Lowest array position wins on overlap.
  - Target index = rule.idx.
  - No match → target ERR (internal index NUM_SLAVES).
- Forwarding:
  - s_req_o[t] = m_req_i & allow.
  - Broadcast fields pass through unregistered.
  - m_gnt_o = allow & (s_gnt_i[t] for a mapped target, or 1 for ERR).
- allow = !fifo_full & (fifo_empty | target == last_target).
  - A request to a different target stalls (no s_req_o, no gnt) until all outstanding responses drain.
  - No bypass: when the FIFO is full, a same-cycle pop does not permit a grant.
- Outstanding FIFO:
  - Depth MAX_OUTSTANDING, storing the target index; last_target register.
  - Push on every grant (m_req_i & m_gnt_o); pop on m_rvalid_o.
  - Simultaneous push/pop keeps the count constant.
- Response path:
  - m_rvalid_o = s_rvalid_i[head] for a mapped head; m_rdata_o = s_rdata_i[head].
  - s_rvalid_i on a non-head port, or with the FIFO empty, is ignored (verification assertion).
- Error responder:
  - A granted ERR access sets err_pending.
  - If ERR is head, the response is registered: m_rvalid_o=1, m_rdata_o=ERR_RDATA, err_o=1 exactly one cycle after the grant.
  - Back-to-back ERR grants give back-to-back responses (pending counter, width log2(MAX_OUTSTANDING)+1).
  - Writes to ERR also produce rvalid; rdata = ERR_RDATA.
- Reset values: m_gnt_o=0 (while m_req_i=0), m_rvalid_o=0, m_rdata_o=0, s_req_o=0, err_o=0, err_count_o=0, FIFO empty, err_pending=0.
- Reset mid-operation: all tracking is discarded, and responses arriving the cycle after reset release are dropped (FIFO empty). Upstream must be reset together with this block.
- m_rdata_o = 0 whenever m_rvalid_o=0.

Optional Feature:
- Macro: OBI_DEMUX_ERR_COUNT_EN.
- When defined:
  - err_count_o increments on each err_o pulse.
  - It saturates at 16'hFFFF and clears only on reset.
- When not defined: err_count_o is tied to 16'h0 and the counter flops are absent.

Test Plan:
- Single read to 0x200B0004 (rule idx 12), s_gnt_i[12]=1, s_rvalid_i[12] next cycle with rdata 0x1234 → s_req_o[12]=1 only; m_gnt_o=1; m_rvalid_o=1 with m_rdata_o=0x1234; FIFO returns to empty.
- Read to 0x200F0000 (unmapped) → m_gnt_o=1 same cycle; no s_req_o; next cycle m_rvalid_o=1, m_rdata_o=0xBADACCE5, err_o=1; err_count_o=1 only with the macro defined.
- Two back-to-back reads to idx 2 (0x20020000, 0x20020004) with slave rvalid delayed 3 cycles → both granted; a third request stalls (FIFO full, m_gnt_o=0) until the first rvalid, and is granted the cycle after.
- Read to idx 0 outstanding, then request to idx 7 (0x20060000) → idx 7 s_req_o held 0 and m_gnt_o=0 until the idx 0 rvalid, then granted next cycle; responses ordered idx0 then idx7.
- rst_ni low for 1 cycle while 2 transactions are outstanding → all outputs at reset values; a late s_rvalid_i after reset produces no m_rvalid_o.
